// File: rtl/branch_update_queue_pkg.sv
// Shared types and default sizing for the retired-branch update channel
// between the ROB and the branch predictor.
//
// Contents:
//   PC_t                  - program counter type
//   BRANCH_UPDATE_ENTRY_t - one queued predictor update
//   ROB_RETIRE_WIDTH      - ROB retire width, reused as the default enqueue width
//   BUQ_*                 - default parameters for branch_update_queue
package branch_update_queue_pkg;

    localparam int PC_WIDTH = 32;
    typedef logic [PC_WIDTH-1:0] PC_t;

    localparam int ROB_RETIRE_WIDTH = 3;

    localparam int BUQ_IN_WIDTH  = ROB_RETIRE_WIDTH;
    localparam int BUQ_OUT_WIDTH = 2;
    localparam int BUQ_DEPTH     = 16;

    typedef struct packed {
        PC_t  source_pc;
        PC_t  target_pc;
        logic taken;
        logic correct;
    } BRANCH_UPDATE_ENTRY_t;

endpackage

// File: rtl/branch_update_queue_compactor.sv
// update_compactor: turns a possibly sparse per-lane valid mask into a
// dense write offset per lane (exclusive prefix popcount) plus the total
// number of valid lanes. Purely combinational; usable by any multi-lane
// queue that packs sparse inputs into consecutive slots.
//
// Ports:
//   in_valid    in  IN_WIDTH           per-lane valid mask
//   lane_offset out IN_WIDTH*OFF_W     slot offset of lane i (valid lanes only meaningful)
//   enq_n       out OFF_W              popcount(in_valid)
module update_compactor #(
    parameter int IN_WIDTH = 3,
    parameter int OFF_W    = $clog2(IN_WIDTH + 1)
) (
    input  logic [IN_WIDTH-1:0]       in_valid,
    output logic [IN_WIDTH*OFF_W-1:0] lane_offset,
    output logic [OFF_W-1:0]          enq_n
);

    logic [OFF_W-1:0] running;

    // NOTE: blocking assignments here are intentional: 'running' is a
    // combinational accumulator read back within the same loop iteration.
    always_comb begin
        running     = '0;
        lane_offset = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            lane_offset[i*OFF_W +: OFF_W] = running;
            running = running + OFF_W'(in_valid[i]);
        end
        enq_n = running;
    end

endmodule

// File: rtl/branch_update_queue.sv
// branch_update_queue: multi-port FIFO between ROB retirement and branch
// predictor training. Accepts up to IN_WIDTH sparse updates per cycle,
// compacts them in lane order, and presents up to OUT_WIDTH oldest entries
// per cycle under valid/ready. No input-to-output bypass.
//
// Ports:
//   clock, reset          clock; asynchronous active-low reset
//   in_valid/in_*         enqueue lanes (lane 0 oldest)
//   in_ready              room for a full IN_WIDTH burst (registered count only)
//   out_valid/out_*       thermometer-valid head entries, oldest in lane 0
//   out_ready             consume every valid out lane this cycle
//   count                 current occupancy
// Optional (macro BRANCH_UPDATE_QUEUE_STATS_EN):
//   stat_stall_cycles, stat_high_water, stat_mispred - saturating counters
module branch_update_queue
    import branch_update_queue_pkg::*;
#(
    parameter int IN_WIDTH  = BUQ_IN_WIDTH,
    parameter int OUT_WIDTH = BUQ_OUT_WIDTH,
    parameter int DEPTH     = BUQ_DEPTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [IN_WIDTH-1:0]           in_valid,
    input  logic [IN_WIDTH*PC_WIDTH-1:0]  in_source_pc,
    input  logic [IN_WIDTH*PC_WIDTH-1:0]  in_target_pc,
    input  logic [IN_WIDTH-1:0]           in_taken,
    input  logic [IN_WIDTH-1:0]           in_correct,
    output logic                          in_ready,
    output logic [OUT_WIDTH-1:0]          out_valid,
    output logic [OUT_WIDTH*PC_WIDTH-1:0] out_source_pc,
    output logic [OUT_WIDTH*PC_WIDTH-1:0] out_target_pc,
    output logic [OUT_WIDTH-1:0]          out_taken,
    output logic [OUT_WIDTH-1:0]          out_correct,
    input  logic                          out_ready,
    output logic [$clog2(DEPTH+1)-1:0]    count
`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
    ,
    output logic [31:0]                   stat_stall_cycles,
    output logic [$clog2(DEPTH+1)-1:0]    stat_high_water,
    output logic [31:0]                   stat_mispred
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OFF_W = $clog2(IN_WIDTH + 1);

    logic [PTR_W-1:0]          head;
    logic [PTR_W-1:0]          tail;
    logic [IN_WIDTH*OFF_W-1:0] lane_offset;
    logic [OFF_W-1:0]          enq_n;
    logic [CNT_W-1:0]          deq_n;
    logic                      enq_fire;

    BRANCH_UPDATE_ENTRY_t mem [DEPTH];
    BRANCH_UPDATE_ENTRY_t in_entry [IN_WIDTH];

    update_compactor #(
        .IN_WIDTH (IN_WIDTH),
        .OFF_W    (OFF_W)
    ) u_compactor (
        .in_valid    (in_valid),
        .lane_offset (lane_offset),
        .enq_n       (enq_n)
    );

    always_comb begin
        for (int i = 0; i < IN_WIDTH; i++) begin
            in_entry[i].source_pc = in_source_pc[i*PC_WIDTH +: PC_WIDTH];
            in_entry[i].target_pc = in_target_pc[i*PC_WIDTH +: PC_WIDTH];
            in_entry[i].taken     = in_taken[i];
            in_entry[i].correct   = in_correct[i];
        end
    end

    // All-or-nothing admission from the registered count; a dequeue in the
    // same cycle earns no credit, keeping in_ready off the out_ready path.
    assign in_ready = (count <= CNT_W'(DEPTH - IN_WIDTH));
    assign enq_fire = in_ready && (|in_valid);

    always_comb begin
        deq_n = '0;
        if (out_ready) begin
            deq_n = (count < CNT_W'(OUT_WIDTH)) ? count : CNT_W'(OUT_WIDTH);
        end
    end

    // NOTE: the entry storage has no reset: head/tail/count define which
    // slots are live, so stale contents are never observed as valid.
    always_ff @(posedge clock) begin
        if (enq_fire) begin
            for (int i = 0; i < IN_WIDTH; i++) begin
                if (in_valid[i]) begin
                    mem[tail + PTR_W'(lane_offset[i*OFF_W +: OFF_W])] <= in_entry[i];
                end
            end
        end
    end

    // Pointers wrap modulo DEPTH through natural PTR_W-bit overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq_fire) begin
                tail <= tail + PTR_W'(enq_n);
            end
            head  <= head + PTR_W'(deq_n);
            count <= count + (enq_fire ? CNT_W'(enq_n) : CNT_W'(0)) - deq_n;
        end
    end

    always_comb begin
        out_valid     = '0;
        out_source_pc = '0;
        out_target_pc = '0;
        out_taken     = '0;
        out_correct   = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            out_valid[i]                         = (CNT_W'(i) < count);
            out_source_pc[i*PC_WIDTH +: PC_WIDTH] = mem[head + PTR_W'(i)].source_pc;
            out_target_pc[i*PC_WIDTH +: PC_WIDTH] = mem[head + PTR_W'(i)].target_pc;
            out_taken[i]                         = mem[head + PTR_W'(i)].taken;
            out_correct[i]                       = mem[head + PTR_W'(i)].correct;
        end
    end

`ifndef SYNTHESIS
    // Producer must never present updates while the queue refuses a burst.
    no_enqueue_when_not_ready: assert property (
        @(posedge clock) disable iff (!reset) !((|in_valid) && !in_ready)
    );
`endif

`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
    logic [OFF_W-1:0] mis_n;
    logic [32:0]      mispred_sum;

    always_comb begin
        mis_n = '0;
        if (enq_fire) begin
            for (int i = 0; i < IN_WIDTH; i++) begin
                mis_n = mis_n + OFF_W'(in_valid[i] && !in_correct[i]);
            end
        end
        mispred_sum = {1'b0, stat_mispred} + 33'(mis_n);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_stall_cycles <= '0;
            stat_high_water   <= '0;
            stat_mispred      <= '0;
        end else begin
            if ((|in_valid) && !in_ready && (stat_stall_cycles != '1)) begin
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            end
            if (count > stat_high_water) begin
                stat_high_water <= count;
            end
            stat_mispred <= mispred_sum[32] ? '1 : mispred_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_branch_update_queue.sv
// Randomized scoreboard bench for branch_update_queue. The reference model
// is a plain queue of expected entries plus an occupancy integer; a driver
// issues stimulus and pushes accepted entries, a monitor pops and compares
// whenever the DUT presents consumed output lanes.
module tb_branch_update_queue;
    import branch_update_queue_pkg::*;

    localparam int IN_WIDTH  = 3;
    localparam int OUT_WIDTH = 2;
    localparam int DEPTH     = 16;
    localparam int CNT_W     = $clog2(DEPTH + 1);

    logic                          clk;
    logic                          rst_n;
    logic [IN_WIDTH-1:0]           in_valid;
    logic [IN_WIDTH*PC_WIDTH-1:0]  in_source_pc;
    logic [IN_WIDTH*PC_WIDTH-1:0]  in_target_pc;
    logic [IN_WIDTH-1:0]           in_taken;
    logic [IN_WIDTH-1:0]           in_correct;
    logic                          in_ready;
    logic [OUT_WIDTH-1:0]          out_valid;
    logic [OUT_WIDTH*PC_WIDTH-1:0] out_source_pc;
    logic [OUT_WIDTH*PC_WIDTH-1:0] out_target_pc;
    logic [OUT_WIDTH-1:0]          out_taken;
    logic [OUT_WIDTH-1:0]          out_correct;
    logic                          out_ready;
    logic [CNT_W-1:0]              count;
`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
    logic [31:0]                   stat_stall_cycles;
    logic [CNT_W-1:0]              stat_high_water;
    logic [31:0]                   stat_mispred;
`endif

    branch_update_queue #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .DEPTH     (DEPTH)
    ) dut (
        .clock             (clk),
        .reset             (rst_n),
        .in_valid          (in_valid),
        .in_source_pc      (in_source_pc),
        .in_target_pc      (in_target_pc),
        .in_taken          (in_taken),
        .in_correct        (in_correct),
        .in_ready          (in_ready),
        .out_valid         (out_valid),
        .out_source_pc     (out_source_pc),
        .out_target_pc     (out_target_pc),
        .out_taken         (out_taken),
        .out_correct       (out_correct),
        .out_ready         (out_ready),
        .count             (count)
`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
        ,
        .stat_stall_cycles (stat_stall_cycles),
        .stat_high_water   (stat_high_water),
        .stat_mispred      (stat_mispred)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    BRANCH_UPDATE_ENTRY_t exp_q[$];
    int model_count;
    int model_hw;
    int model_mis;
    int total_pushed;

    int checks;
    int errors;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic model_ready();
        return (DEPTH - model_count) >= IN_WIDTH;
    endfunction

    // One clock of stimulus. Occupancy-level checks happen first, then the
    // inputs are driven; the model only enqueues when it expects in_ready.
    task automatic step(input logic [IN_WIDTH-1:0] v_req, input logic ordy, input logic [31:0] base);
        logic [IN_WIDTH-1:0]  v;
        logic [OUT_WIDTH-1:0] eov;
        BRANCH_UPDATE_ENTRY_t e;
        int enq;
        int deq;
        @(negedge clk);
        for (int i = 0; i < OUT_WIDTH; i++) eov[i] = (i < model_count);
        check("count", 64'(count), 64'(model_count));
        check("in_ready", 64'(in_ready), 64'(model_ready()));
        check("out_valid", 64'(out_valid), 64'(eov));
        v   = model_ready() ? v_req : '0;
        enq = 0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (base != 0) begin
                e.source_pc = base + 32'(4 * i);
                e.target_pc = base + 32'h1000 + 32'(4 * i);
            end else begin
                e.source_pc = $urandom;
                e.target_pc = $urandom;
            end
            e.taken   = 1'($urandom);
            e.correct = 1'($urandom);
            in_source_pc[i*PC_WIDTH +: PC_WIDTH] = e.source_pc;
            in_target_pc[i*PC_WIDTH +: PC_WIDTH] = e.target_pc;
            in_taken[i]   = e.taken;
            in_correct[i] = e.correct;
            if (v[i]) begin
                exp_q.push_back(e);
                enq++;
                if (!e.correct) model_mis++;
            end
        end
        in_valid  = v;
        out_ready = ordy;
        deq = ordy ? ((model_count < OUT_WIDTH) ? model_count : OUT_WIDTH) : 0;
        model_count  = model_count + enq - deq;
        total_pushed = total_pushed + enq;
        if (model_count > model_hw) model_hw = model_count;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && model_count > 0; k++) step('0, 1'b1, 32'h0);
        step('0, 1'b0, 32'h0);
    endtask

    // Monitor: every valid lane consumed this cycle must match the oldest
    // expected entry.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && out_ready) begin
                for (int i = 0; i < OUT_WIDTH; i++) begin
                    if (out_valid[i]) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL sb_underflow: lane %0d valid, expected no entry at %0t", i, $time);
                        end else begin
                            BRANCH_UPDATE_ENTRY_t e;
                            e = exp_q.pop_front();
                            check("out_source_pc", 64'(out_source_pc[i*PC_WIDTH +: PC_WIDTH]), 64'(e.source_pc));
                            check("out_target_pc", 64'(out_target_pc[i*PC_WIDTH +: PC_WIDTH]), 64'(e.target_pc));
                            check("out_taken_correct", 64'({out_taken[i], out_correct[i]}), 64'({e.taken, e.correct}));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        model_count = 0; model_hw = 0; model_mis = 0; total_pushed = 0;
        rst_n = 1'b0;
        in_valid = '0; in_source_pc = '0; in_target_pc = '0;
        in_taken = '0; in_correct = '0; out_ready = 1'b0;

        #23;
        check("reset_count", 64'(count), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Sparse lanes compact into consecutive slots.
        step(3'b101, 1'b0, 32'h100);
        step(3'b000, 1'b0, 32'h0);
        check("sparse_lane0_pc", 64'(out_source_pc[0 +: PC_WIDTH]), 64'h100);
        check("sparse_lane1_pc", 64'(out_source_pc[PC_WIDTH +: PC_WIDTH]), 64'h108);

        // Reach count=5, then reset asynchronously in the middle of a burst.
        step(3'b111, 1'b0, 32'h0);
        @(negedge clk);
        check("pre_reset_count", 64'(count), 64'd5);
        in_valid = 3'b111;
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_out_valid", 64'(out_valid), 64'd0);
        check("mid_reset_count", 64'(count), 64'd0);
        exp_q.delete();
        model_count = 0; model_hw = 0; model_mis = 0; total_pushed = 0;
        @(negedge clk);
        in_valid = '0;
        #2 rst_n = 1'b1;
        #1;
        check("post_reset_in_ready", 64'(in_ready), 64'd1);

        // Fill: five full bursts reach 15; a sixth is withheld (in_ready=0).
        for (int b = 0; b < 5; b++) step(3'b111, 1'b0, 32'h0);
        step(3'b111, 1'b0, 32'h0);
        step(3'b000, 1'b0, 32'h0);
        check("full_count_stays_15", 64'(count), 64'd15);
        drain();

        // At 14, a burst is refused while the dequeue proceeds.
        for (int b = 0; b < 4; b++) step(3'b111, 1'b0, 32'h0);
        step(3'b011, 1'b0, 32'h0);
        step(3'b111, 1'b1, 32'h0);
        step(3'b111, 1'b0, 32'h0);
        step(3'b000, 1'b0, 32'h0);
        check("refill_count_15", 64'(count), 64'd15);
        drain();

        // Wrap: place tail at slot 14, then a 3-wide burst spans 14,15,0.
        for (int k = 0; k < 40 && (total_pushed % DEPTH) != 14; k++) step(3'b001, 1'b1, 32'h0);
        drain();
        step(3'b111, 1'b0, 32'h200);
        step(3'b000, 1'b0, 32'h0);
        check("wrap_lane0_pc", 64'(out_source_pc[0 +: PC_WIDTH]), 64'h200);
        check("wrap_lane1_pc", 64'(out_source_pc[PC_WIDTH +: PC_WIDTH]), 64'h204);
        drain();

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            step(IN_WIDTH'($urandom_range(0, 7)), ($urandom_range(0, 2) != 0), 32'h0);
        end
        drain();
        step(3'b000, 1'b0, 32'h0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
        check("stat_stall_cycles", 64'(stat_stall_cycles), 64'd0);
        check("stat_high_water", 64'(stat_high_water), 64'(model_hw));
        check("stat_mispred", 64'(stat_mispred), 64'(model_mis));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_update_queue.md
Name: branch_update_queue

Overview:
- Parametrised successor to the ROB→branch-predictor update channel: a multi-port FIFO between retirement and predictor training.
- Accepts up to IN_WIDTH retired-branch updates per cycle from the ROB, compacts them, and presents up to OUT_WIDTH per cycle to the predictor under valid/ready.
- Decouples retire width from predictor update bandwidth; adds backpressure and the `correct` field end-to-end.

Parameters:
- IN_WIDTH, 3, enqueue lanes (ROB retire width).
- OUT_WIDTH, 2, dequeue lanes (predictor update ports).
- DEPTH, 16, entries; power of two, at least max(IN_WIDTH, OUT_WIDTH).

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  IN_WIDTH  per-lane update valid; may be non-contiguous.
- in_source_pc  in  IN_WIDTH×PC_t  branch PC.
- in_target_pc  in  IN_WIDTH×PC_t  resolved target.
- in_taken  in  IN_WIDTH  resolved direction.
- in_correct  in  IN_WIDTH  prediction was correct.
- in_ready  out  1  queue accepts a full IN_WIDTH burst this cycle.
- out_valid  out  OUT_WIDTH  contiguous from lane 0 (thermometer).
- out_source_pc, out_target_pc  out  OUT_WIDTH×PC_t  head entries, oldest in lane 0.
- out_taken, out_correct  out  OUT_WIDTH  head entry fields.
- out_ready  in  1  predictor consumes every lane with out_valid set this cycle.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset: clock and reset as above; reset is asynchronous and active-low.
  - Asserting reset immediately clears head, tail and count, including mid-burst; entries are discarded.
  - During and after reset: out_valid=0, count=0, in_ready=1. Inputs are ignored while reset is asserted.
- Storage: circular buffer of DEPTH entries {source_pc, target_pc, taken, correct}. head/tail are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- Enqueue:
  - Fires when in_ready and any in_valid bit is set.
  - Valid lanes are compacted in ascending lane order, so lane 0 is oldest, into tail, tail+1, …
  - tail advances by popcount(in_valid).
- in_ready = (DEPTH − count) ≥ IN_WIDTH. All-or-nothing: it is computed from the registered count only, with no credit for a same-cycle dequeue.
- Enqueue when in_ready=0 is a protocol violation; the data is dropped, with a simulation-only assertion.
- Dequeue:
  - out_valid[i] = (i < count), lane i shows entry head+i mod DEPTH.
  - When out_ready=1, head advances by min(count, OUT_WIDTH).
  - out_ready while count=0 is a no-op.
- Count update: count_next = count + enq_n − deq_n. Simultaneous enqueue and dequeue in one cycle is legal and exact.
- Latency:
  - An entry enqueued at edge t is visible on out_* after edge t, i.e. one cycle minimum.
  - There is no input-to-output bypass, even when the queue is empty.
- Ordering: strict FIFO across cycles and lanes; nothing is reordered or coalesced.
- Full: count=DEPTH gives in_ready=0 and out lanes all valid.
- Empty: count=0 gives out_valid=0.
- Wrap: bursts straddling index DEPTH−1→0 must land in consecutive modulo slots.

Optional Feature:
- Macro: BRANCH_UPDATE_QUEUE_STATS_EN.
- When defined, adds three outputs, all cleared by reset and saturating at all-ones:
  - stat_stall_cycles, 32 bits: counts cycles with any in_valid set and in_ready=0.
  - stat_high_water, $clog2(DEPTH+1) bits: maximum count observed.
  - stat_mispred, 32 bits: counts enqueued entries with correct=0.
- When undefined, these ports and their logic are absent; core behaviour is identical.

Decomposition:
- Shared package:
  - PC_t (existing).
  - New typedef BRANCH_UPDATE_ENTRY_t {source_pc, target_pc, taken, correct}.
  - Default width constants, reusing the ROB retire-width constant for IN_WIDTH.
- One sub-module: update_compactor. Combinational: in_valid mask → per-lane slot offset and enq_n (prefix popcount); reusable by other multi-lane queues.
- The branch_predictor side consumes out_* in place of the former update bundle.

Test Plan:
- Reset mid-burst: count=5, assert reset between edges → out_valid=0 and count=0 immediately; in_ready=1 after release.
- Sparse compaction: in_valid=3'b101 with PCs 0x100 (lane 0) and 0x108 (lane 2), out_ready=0 → next cycle count=2, out lane0=0x100, lane1=0x108, out_valid=2'b11.
- Fill to full: in_valid=3'b111 each cycle with out_ready=0.
  - After 5 bursts: count=15, in_ready=0, since 1 free is less than 3.
  - Sixth burst (violation) → assertion fires, count stays 15.
- Simultaneous enqueue/dequeue at count=14: in 3 lanes plus out_ready=1 → in_ready=0, so only the dequeue occurs and count=12. Next cycle, the enqueue of 3 is accepted with out_ready=0 → count=15.
- Wrap-around: advance head/tail to 14, enqueue 3 → entries at slots 14, 15, 0. Drain → PCs emerge in enqueue order across two cycles.
- Stats build: 4 cycles stalled with in_valid≠0, and 2 enqueued entries with correct=0 → stat_stall_cycles=4, stat_mispred=2, stat_high_water=16 after reaching full.
